// File: rtl/multicycle_main_controller_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath/memory.
// Handshake: mem_req stays high until mem_ready is seen with the minimum wait satisfied.
interface multicycle_main_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       instr_done;
    logic       illegal;

    modport master (
        output op, funct3, zero, lt, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_done, illegal
    );

    modport slave (
        input  op, funct3, zero, lt, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        output alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multi-cycle RV32I datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory ready handshake, branch evaluation and illegal-opcode trapping.
module multicycle_main_controller #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_main_controller_if.slave    bus,
    output logic [3:0]                     state_o
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R,
        EXEC_I, ALU_WB, BRANCH, JAL, JALR_ADR, LUI, TRAP
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic                illegal_q, illegal_d;
    logic                wait_met, done, taken, in_mem;

    generate
        if (MEM_WAIT == 0) begin : g_no_wait
            assign wait_met = 1'b1;
        end else begin : g_wait
            assign wait_met = (wcnt_q >= WAIT_W'(MEM_WAIT));
        end
    endgenerate

    assign done    = bus.mem_ready && wait_met;
    assign in_mem  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
    assign state_o = state_q;

    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (done) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEM_ADR;
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR_ADR;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = TRAP;
                endcase
            end
            MEM_ADR:   state_d = (bus.op == OP_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (done) state_d = MEM_WB;
            MEM_WRITE: if (done) state_d = FETCH;
            MEM_WB, ALU_WB, BRANCH, LUI: state_d = FETCH;
            EXEC_R, EXEC_I, JAL:         state_d = ALU_WB;
            JALR_ADR:  state_d = JAL;
            TRAP:      state_d = TRAP;
            default:   state_d = FETCH;
        endcase

        // Wait counter restarts on every state change so each access is timed on its own.
        wcnt_d = wcnt_q;
        if (state_d != state_q)          wcnt_d = '0;
        else if (in_mem && wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;

        illegal_d = illegal_q || (state_d == TRAP);
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.instr_done = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.result_src = 2'b00;
        case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1; bus.alu_src_b = 2'b10; bus.result_src = 2'b10;
                bus.ir_write = done; bus.pc_write = done;
            end
            DECODE:    begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b01; end
            MEM_ADR:   begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; end
            MEM_READ:  begin bus.mem_req = 1'b1; bus.adr_src = 1'b1; end
            MEM_WB:    begin bus.result_src = 2'b01; bus.reg_write = 1'b1; bus.instr_done = 1'b1; end
            MEM_WRITE: begin
                bus.mem_req = 1'b1; bus.mem_write = 1'b1; bus.adr_src = 1'b1;
                bus.instr_done = done;
            end
            EXEC_R:    begin bus.alu_src_a = 2'b10; bus.alu_op = 2'b10; end
            EXEC_I:    begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; bus.alu_op = 2'b10; end
            ALU_WB:    begin bus.reg_write = 1'b1; bus.instr_done = 1'b1; end
            BRANCH: begin
                bus.alu_src_a = 2'b10; bus.alu_op = 2'b01;
                bus.pc_write = taken; bus.instr_done = 1'b1;
            end
            JAL:       begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; bus.pc_write = 1'b1; end
            JALR_ADR:  begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; end
            LUI:       begin bus.result_src = 2'b11; bus.reg_write = 1'b1; bus.instr_done = 1'b1; end
            default:   ;
        endcase
        // Strobes are held off while reset is asserted so an in-flight access never writes.
        if (rst) begin
            bus.mem_req    = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.pc_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.instr_done = 1'b0;
        end
    end

    assign bus.illegal = illegal_q;

    always_comb begin
        case (bus.op)
            OP_STORE: bus.imm_src = 3'b001;
            OP_BR:    bus.imm_src = 3'b010;
            OP_LUI:   bus.imm_src = 3'b011;
            OP_JAL:   bus.imm_src = 3'b100;
            default:  bus.imm_src = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: one instance with no memory wait,
// one with MEM_WAIT=3, each compared cycle by cycle against hand-derived output vectors.
module tb_multicycle_main_controller;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst0, rst3;
    logic [3:0] state0, state3;
    int         errors = 0;
    int         checks = 0;

    // strobe vector: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, illegal}
    // mux vector:    {alu_src_a, alu_src_b, alu_op, result_src}
    logic [7:0] s0, m0, s3, m3;

    logic [2:0] br_f3   [6] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000};
    logic       br_zero [6] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
    logic       br_lt   [6] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
    logic [7:0] br_exp  [6] = '{8'h02,  8'h0A,  8'h02,  8'h0A,  8'h02,  8'h0A};

    multicycle_main_controller_if if0 ();
    multicycle_main_controller_if if3 ();

    multicycle_main_controller #(.MEM_WAIT(0), .WAIT_W(4)) dut0 (
        .clk(clk), .rst(rst0), .bus(if0.slave), .state_o(state0)
    );
    multicycle_main_controller #(.MEM_WAIT(3), .WAIT_W(4)) dut3 (
        .clk(clk), .rst(rst3), .bus(if3.slave), .state_o(state3)
    );

    assign s0 = {if0.mem_req, if0.mem_write, if0.adr_src, if0.ir_write,
                 if0.pc_write, if0.reg_write, if0.instr_done, if0.illegal};
    assign m0 = {if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.result_src};
    assign s3 = {if3.mem_req, if3.mem_write, if3.adr_src, if3.ir_write,
                 if3.pc_write, if3.reg_write, if3.instr_done, if3.illegal};
    assign m3 = {if3.alu_src_a, if3.alu_src_b, if3.alu_op, if3.result_src};

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Called in the FETCH cycle (mem_ready high, no wait) of dut0; leaves the bench in the cycle after DECODE.
    task automatic fetch_decode(input string tag);
        chk({tag, "_fetch"}, s0, 8'h98);
        chk({tag, "_fetch_mux"}, m0, 8'h22);
        tick();
        chk({tag, "_decode"}, s0, 8'h00);
        chk({tag, "_decode_mux"}, m0, 8'h50);
        tick();
    endtask

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        if0.op = OP_R; if0.funct3 = 3'b000; if0.zero = 1'b0; if0.lt = 1'b0; if0.mem_ready = 1'b1;
        if3.op = OP_LOAD; if3.funct3 = 3'b000; if3.zero = 1'b0; if3.lt = 1'b0; if3.mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_strobes0", s0, 8'h00);
        chk("rst_strobes3", s3, 8'h00);

        // R-type, 4 cycles
        rst0 = 1'b0;
        #1;
        fetch_decode("r");
        chk("r_exec", s0, 8'h00);
        chk("r_exec_mux", m0, 8'h88);
        tick();
        chk("r_wb", s0, 8'h06);
        chk("r_wb_mux", m0, 8'h00);
        tick();

        // Branch condition table
        for (int i = 0; i < 6; i++) begin
            if0.op = OP_BR; if0.funct3 = br_f3[i]; if0.zero = br_zero[i]; if0.lt = br_lt[i];
            #1;
            fetch_decode($sformatf("br%0d", i));
            chk($sformatf("br%0d_branch", i), s0, br_exp[i]);
            chk($sformatf("br%0d_branch_mux", i), m0, 8'h84);
            tick();
        end
        chk("br_imm_src", {5'b0, if0.imm_src}, 8'h02);

        // I-type
        if0.op = OP_I; #1;
        fetch_decode("i");
        chk("i_exec_mux", m0, 8'h98);
        tick();
        chk("i_wb", s0, 8'h06);
        tick();

        // LUI, 3 cycles
        if0.op = OP_LUI; #1;
        chk("lui_imm_src", {5'b0, if0.imm_src}, 8'h03);
        fetch_decode("lui");
        chk("lui_wb", s0, 8'h06);
        chk("lui_wb_mux", m0, 8'h03);
        tick();

        // JALR -> JAL -> ALU_WB
        if0.op = OP_JALR; #1;
        fetch_decode("jalr");
        chk("jalr_adr", s0, 8'h00);
        chk("jalr_adr_mux", m0, 8'h90);
        tick();
        chk("jalr_jal", s0, 8'h08);
        chk("jalr_jal_mux", m0, 8'h60);
        tick();
        chk("jalr_wb", s0, 8'h06);
        chk("jalr_wb_mux", m0, 8'h00);
        tick();

        // JAL
        if0.op = OP_JAL; #1;
        chk("jal_imm_src", {5'b0, if0.imm_src}, 8'h04);
        fetch_decode("jal");
        chk("jal_jal", s0, 8'h08);
        tick();
        chk("jal_wb", s0, 8'h06);
        tick();

        // Store with mem_ready low for 5 MEM_WRITE cycles
        if0.op = OP_STORE; #1;
        chk("st_imm_src", {5'b0, if0.imm_src}, 8'h01);
        fetch_decode("st");
        chk("st_adr", s0, 8'h00);
        chk("st_adr_mux", m0, 8'h90);
        if0.mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("st_wait%0d", k), s0, 8'hE0);
        end
        tick();
        if0.mem_ready = 1'b1;
        #1;
        chk("st_done", s0, 8'hE2);
        chk("st_done_mux", m0, 8'h00);
        tick();
        if0.op = OP_R; #1;
        chk("st_next_fetch", s0, 8'h98);

        // Illegal opcode trap, then reset out of it
        if0.op = OP_BAD; #1;
        fetch_decode("trap");
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("trap%0d", k), s0, 8'h01);
            chk($sformatf("trap%0d_mux", k), m0, 8'h00);
            tick();
        end
        rst0 = 1'b1;
        #1;
        chk("trap_rst", s0, 8'h00);
        tick();
        tick();
        chk("trap_rst_held", s0, 8'h00);
        rst0 = 1'b0;
        if0.op = OP_R;
        #1;
        chk("trap_resume_fetch", s0, 8'h98);

        // MEM_WAIT=3 load: instr_done in cycle 11 after reset release
        chk("w3_rst_held", s3, 8'h00);
        rst3 = 1'b0;
        #1;
        for (int c = 1; c <= 12; c++) begin
            case (c)
                1, 2, 3:        chk($sformatf("w3_c%0d", c), s3, 8'h80);
                4:              chk("w3_c4", s3, 8'h98);
                5, 6:           chk($sformatf("w3_c%0d", c), s3, 8'h00);
                7, 8, 9, 10:    chk($sformatf("w3_c%0d", c), s3, 8'hA0);
                11: begin
                    chk("w3_c11", s3, 8'h06);
                    chk("w3_c11_mux", m3, 8'h01);
                end
                default:        chk("w3_c12", s3, 8'h80);
            endcase
            if (c == 6) chk("w3_memadr_mux", m3, 8'h90);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
